tile_nv_rd_sched: RTL
=====================

TILE_NV_RD_SCHED -- requirements
Module: tile_nv_rd_sched

Interface
REQ-001 SHALL have parameter NV_IDX_WIDTH, default 7, the width of a tile BRAM Native Vector (NV) index (128 NVs per side).
REQ-002 SHALL have parameter DIM_WIDTH, default 8, the width of each loop-dimension field.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 SHALL have port i_reset, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port i_cmd_valid, input, 1, a command is presented.
REQ-006 SHALL have port o_cmd_ready, output, 1, the scheduler can accept a command.
REQ-007 SHALL have port i_left_base, input, NV_IDX_WIDTH, the first left NV index.
REQ-008 SHALL have port i_right_base, input, NV_IDX_WIDTH, the first right NV index.
REQ-009 SHALL have ports i_dim_b, i_dim_c and i_dim_v, each input, DIM_WIDTH: left row count, right column count and NVs per dot product.
REQ-010 SHALL have ports o_nv_left_rd_idx and o_nv_right_rd_idx, each output, NV_IDX_WIDTH, the NV read indices that drive the tile BRAM.
REQ-011 SHALL have port o_rd_valid, output, 1, the index pair is valid.
REQ-012 SHALL have port i_rd_ready, input, 1, the compute consumer accepts the index pair.
REQ-013 SHALL have port o_last_v, output, 1, qualifies o_rd_valid: the pair is the final v of the current (b,c) dot product.
REQ-014 SHALL have port o_done, output, 1, a one-cycle pulse at command completion.
REQ-015 SHALL have port o_err, output, 1, a one-cycle pulse when a command is rejected as empty.
REQ-016 SHALL have port o_busy, output, 1, high in any state other than IDLE.

Function
REQ-017 SHALL implement the states IDLE, RUN and DONE.
REQ-018 SHALL drive o_cmd_ready=1 only in IDLE; a command is accepted on a cycle where i_cmd_valid and o_cmd_ready are both high.
REQ-019 SHALL latch all command fields at acceptance; input changes after acceptance SHALL have no effect.
REQ-020 SHALL, when a command is accepted with any dimension equal to 0, go to DONE, assert o_err together with o_done on the next cycle, and issue no o_rd_valid.
REQ-021 SHALL otherwise go to RUN with b=c=v=0 and assert o_rd_valid in the cycle after acceptance, all outputs registered.
REQ-022 SHALL compute o_nv_left_rd_idx = (left_base + b*dim_v + v) mod 2^NV_IDX_WIDTH.
REQ-023 SHALL compute o_nv_right_rd_idx = (right_base + c*dim_v + v) mod 2^NV_IDX_WIDTH.
REQ-024 SHALL compute the REQ-022/REQ-023 indices with running-offset adders, not multipliers, and SHALL let them wrap silently.
REQ-025 SHALL iterate with v innermost, then c, then b outermost.
REQ-026 SHALL assert o_last_v when v == dim_v-1.
REQ-027 SHALL hold o_rd_valid, both indices and o_last_v stable while o_rd_valid=1 and i_rd_ready=0.
REQ-028 SHALL advance exactly one step per handshake (o_rd_valid & i_rd_ready) and sustain one pair per cycle while i_rd_ready is held high.
REQ-029 SHALL issue exactly dim_b*dim_c*dim_v handshakes per command.
REQ-030 SHALL, on the handshake with b=dim_b-1, c=dim_c-1 and v=dim_v-1, deassert o_rd_valid on the next cycle and enter DONE.
REQ-031 SHALL pulse o_done for exactly one cycle in DONE, then return to IDLE, so o_cmd_ready rises on the cycle after o_done.
REQ-032 SHALL ignore i_rd_ready while o_rd_valid=0.
REQ-033 SHALL ignore i_cmd_valid outside IDLE; commands SHALL NOT be queued.

Reset
REQ-034 SHALL, while i_reset=1 at a clock edge, including mid-RUN, enter IDLE on that edge and drive o_rd_valid=0, o_done=0, o_err=0, o_busy=0, o_last_v=0, o_cmd_ready=1 and both indices = 0.
REQ-035 SHALL discard any in-flight command on reset and produce no o_done for it.

Verification
REQ-036 SHALL be verified with this stimulus: base L=0, R=0, B=2, C=2, V=2, i_rd_ready held 1. Required response: 8 consecutive valid cycles, (L,R) = (0,0),(1,1),(0,2),(1,3),(2,0),(3,1),(2,2),(3,3), o_last_v on the odd beats, then o_done one cycle later.
REQ-037 SHALL be verified with this stimulus: the REQ-036 command with i_rd_ready toggled 1,0,0,1... Required response: indices stable across stalls, the same 8-pair sequence, no pair skipped or repeated.
REQ-038 SHALL be verified with this stimulus: L=126, R=127, B=1, C=1, V=4. Required response: L sequence 126,127,0,1 and R sequence 127,0,1,2.
REQ-039 SHALL be verified with this stimulus: a command with V=0. Required response: no o_rd_valid, o_err and o_done pulse together two cycles after acceptance, and o_cmd_ready high the following cycle.
REQ-040 SHALL be verified with this stimulus: i_reset asserted for one cycle at beat 3 of the REQ-036 command. Required response: o_rd_valid=0 on the next cycle, no o_done, and a following command starts from (0,0).
REQ-041 SHALL be verified with this stimulus: i_cmd_valid held high during RUN with different fields. Required response: the running command's sequence is unaffected, and the new command is accepted only after o_done.

Source files
------------

// File: rtl/tile_nv_rd_sched.sv
// Tile BRAM Native Vector read scheduler.
// Accepts one (left_base, right_base, B, C, V) command and issues the
// B*C*V left/right NV read-index pairs. v is the innermost loop, then c,
// then b. The index arithmetic uses running offsets, so no multiplier is
// needed. Every output is registered and held stable while the consumer stalls.
module tile_nv_rd_sched #(
    parameter int NV_IDX_WIDTH = 7,
    parameter int DIM_WIDTH    = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [NV_IDX_WIDTH-1:0] i_left_base,
    input  logic [NV_IDX_WIDTH-1:0] i_right_base,
    input  logic [DIM_WIDTH-1:0]    i_dim_b,
    input  logic [DIM_WIDTH-1:0]    i_dim_c,
    input  logic [DIM_WIDTH-1:0]    i_dim_v,
    output logic [NV_IDX_WIDTH-1:0] o_nv_left_rd_idx,
    output logic [NV_IDX_WIDTH-1:0] o_nv_right_rd_idx,
    output logic                    o_rd_valid,
    input  logic                    i_rd_ready,
    output logic                    o_last_v,
    output logic                    o_done,
    output logic                    o_err,
    output logic                    o_busy
);

    localparam logic [DIM_WIDTH-1:0]    DIM_ZERO = '0;
    localparam logic [DIM_WIDTH-1:0]    DIM_ONE  = {{(DIM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NV_IDX_WIDTH-1:0] NV_ZERO  = '0;
    localparam logic [NV_IDX_WIDTH-1:0] NV_ONE   = {{(NV_IDX_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_r;

    // Latched command fields
    logic [DIM_WIDTH-1:0]    dim_b_r;
    logic [DIM_WIDTH-1:0]    dim_c_r;
    logic [DIM_WIDTH-1:0]    dim_v_r;
    logic [NV_IDX_WIDTH-1:0] right_base_r;

    // Loop counters and running offsets
    logic [DIM_WIDTH-1:0]    b_r;
    logic [DIM_WIDTH-1:0]    c_r;
    logic [DIM_WIDTH-1:0]    v_r;
    logic [NV_IDX_WIDTH-1:0] left_row_r;   // left_base + b*dim_v
    logic [NV_IDX_WIDTH-1:0] right_col_r;  // right_base + c*dim_v
    logic                    err_pend_r;   // empty command: error pulse still owed

    // Registered outputs
    logic [NV_IDX_WIDTH-1:0] left_idx_r;
    logic [NV_IDX_WIDTH-1:0] right_idx_r;
    logic                    rd_valid_r;
    logic                    last_v_r;
    logic                    done_r;
    logic                    err_r;
    logic                    busy_r;
    logic                    cmd_ready_r;

    // Decoded conditions
    logic                    handshake_s;
    logic                    v_end_s;
    logic                    c_end_s;
    logic                    b_end_s;
    logic                    next_last_v_s;
    logic                    cmd_empty_s;
    logic [NV_IDX_WIDTH-1:0] step_v_s;
    logic [NV_IDX_WIDTH-1:0] left_row_next_s;
    logic [NV_IDX_WIDTH-1:0] right_col_next_s;

    // Loop-boundary decode and running-offset increments
    always_comb begin
        handshake_s      = rd_valid_r & i_rd_ready;
        v_end_s          = (v_r == (dim_v_r - DIM_ONE));
        c_end_s          = (c_r == (dim_c_r - DIM_ONE));
        b_end_s          = (b_r == (dim_b_r - DIM_ONE));
        next_last_v_s    = ((v_r + DIM_ONE) == (dim_v_r - DIM_ONE));
        cmd_empty_s      = (i_dim_b == DIM_ZERO) | (i_dim_c == DIM_ZERO) | (i_dim_v == DIM_ZERO);
        step_v_s         = NV_IDX_WIDTH'(dim_v_r);
        left_row_next_s  = left_row_r + step_v_s;
        right_col_next_s = right_col_r + step_v_s;
    end

    // Scheduler FSM: command acceptance, index stepping, completion and error pulses
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r      <= ST_IDLE;
            dim_b_r      <= DIM_ZERO;
            dim_c_r      <= DIM_ZERO;
            dim_v_r      <= DIM_ZERO;
            right_base_r <= NV_ZERO;
            b_r          <= DIM_ZERO;
            c_r          <= DIM_ZERO;
            v_r          <= DIM_ZERO;
            left_row_r   <= NV_ZERO;
            right_col_r  <= NV_ZERO;
            err_pend_r   <= 1'b0;
            left_idx_r   <= NV_ZERO;
            right_idx_r  <= NV_ZERO;
            rd_valid_r   <= 1'b0;
            last_v_r     <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            cmd_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                    if (i_cmd_valid) begin
                        dim_b_r      <= i_dim_b;
                        dim_c_r      <= i_dim_c;
                        dim_v_r      <= i_dim_v;
                        right_base_r <= i_right_base;
                        left_row_r   <= i_left_base;
                        right_col_r  <= i_right_base;
                        b_r          <= DIM_ZERO;
                        c_r          <= DIM_ZERO;
                        v_r          <= DIM_ZERO;
                        cmd_ready_r  <= 1'b0;
                        busy_r       <= 1'b1;
                        if (cmd_empty_s) begin
                            // Nothing to issue: report through DONE with an error pulse
                            state_r    <= ST_DONE;
                            err_pend_r <= 1'b1;
                            rd_valid_r <= 1'b0;
                            last_v_r   <= 1'b0;
                        end else begin
                            state_r     <= ST_RUN;
                            err_pend_r  <= 1'b0;
                            rd_valid_r  <= 1'b1;
                            left_idx_r  <= i_left_base;
                            right_idx_r <= i_right_base;
                            last_v_r    <= (i_dim_v == DIM_ONE);
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (handshake_s) begin
                        if (!v_end_s) begin
                            // Next v of the same dot product: both indices step by one
                            v_r         <= v_r + DIM_ONE;
                            left_idx_r  <= left_idx_r + NV_ONE;
                            right_idx_r <= right_idx_r + NV_ONE;
                            last_v_r    <= next_last_v_s;
                        end else if (!c_end_s) begin
                            // Next column: same left row, right jumps by dim_v
                            v_r         <= DIM_ZERO;
                            c_r         <= c_r + DIM_ONE;
                            right_col_r <= right_col_next_s;
                            right_idx_r <= right_col_next_s;
                            left_idx_r  <= left_row_r;
                            last_v_r    <= (dim_v_r == DIM_ONE);
                        end else if (!b_end_s) begin
                            // Next row: left jumps by dim_v, right restarts at its base
                            v_r         <= DIM_ZERO;
                            c_r         <= DIM_ZERO;
                            b_r         <= b_r + DIM_ONE;
                            left_row_r  <= left_row_next_s;
                            left_idx_r  <= left_row_next_s;
                            right_col_r <= right_base_r;
                            right_idx_r <= right_base_r;
                            last_v_r    <= (dim_v_r == DIM_ONE);
                        end else begin
                            // Final pair accepted: stop issuing and report completion
                            v_r        <= DIM_ZERO;
                            c_r        <= DIM_ZERO;
                            b_r        <= DIM_ZERO;
                            rd_valid_r <= 1'b0;
                            last_v_r   <= 1'b0;
                            done_r     <= 1'b1;
                            state_r    <= ST_DONE;
                        end
                    end else begin
                        // Stall or waiting: hold every output
                        rd_valid_r <= rd_valid_r;
                    end
                end

                ST_DONE: begin
                    if (err_pend_r) begin
                        err_pend_r <= 1'b0;
                        done_r     <= 1'b1;
                        err_r      <= 1'b1;
                    end else begin
                        done_r      <= 1'b0;
                        err_r       <= 1'b0;
                        busy_r      <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    err_pend_r  <= 1'b0;
                    rd_valid_r  <= 1'b0;
                    last_v_r    <= 1'b0;
                    done_r      <= 1'b0;
                    err_r       <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign o_cmd_ready       = cmd_ready_r;
    assign o_nv_left_rd_idx  = left_idx_r;
    assign o_nv_right_rd_idx = right_idx_r;
    assign o_rd_valid        = rd_valid_r;
    assign o_last_v          = last_v_r;
    assign o_done            = done_r;
    assign o_err             = err_r;
    assign o_busy            = busy_r;

endmodule
